// File: rtl/key_lock_ctl_pkg.sv
// Shared types and constants for the keypad lock controller.
package key_lock_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    localparam logic [3:0]  KEY_CLR    = 4'hA;
    localparam logic [3:0]  KEY_ENT    = 4'hB;
    localparam logic [23:0] BLANK_DISP = 24'hFFFFFF;
    localparam logic [23:0] ERR_DISP   = 24'hEEEEEE;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold n-1, never less than one.
    function automatic int timer_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_lock_ctl_timer.sv
// Down-counting dwell timer: loads a value, counts to zero and holds there.
module lock_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Load has priority over the decrement; the count parks at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/key_lock_ctl.sv
// Keypad code lock: collects six BCD digits, checks them against PASSWORD,
// then opens, flags a failure, or locks out after repeated failures.
module key_lock_ctl
    import key_lock_ctl_pkg::*;
#(
    parameter logic [23:0] PASSWORD    = 24'h123456,
    parameter int          MAX_FAIL    = 3,
    parameter int          OPEN_CYCLES = 32,
    parameter int          FAIL_CYCLES = 8,
    parameter int          LOCK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [23:0] display_code,
    output logic [2:0]  digit_cnt,
    output logic        unlocked,
    output logic        alarm
);

    localparam int         TW         = timer_width(max3(OPEN_CYCLES, FAIL_CYCLES, LOCK_CYCLES));
    localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);

    state_t          state_r, next_state_s;
    logic [23:0]     display_r, display_nxt_s;
    logic [2:0]      digit_cnt_r, digit_cnt_nxt_s;
    logic [2:0]      fail_cnt_r, fail_cnt_nxt_s, fail_inc_s;
    logic            unlocked_r, alarm_r, unlocked_nxt_s, alarm_nxt_s;
    logic            timer_load_s, timer_zero_s;
    logic [TW-1:0]   timer_val_s;
    logic            match_s, key_clr_s, key_ent_s, key_dig_s;

    assign key_clr_s  = key_valid && (key_code == KEY_CLR);
    assign key_ent_s  = key_valid && (key_code == KEY_ENT);
    assign key_dig_s  = key_valid && is_digit(key_code);
    assign match_s    = (digit_cnt_r == 3'd6) && (display_r == PASSWORD);
    assign fail_inc_s = (fail_cnt_r >= MAX_FAIL_C) ? fail_cnt_r : fail_cnt_r + 3'd1;

    // The dwell timer is loaded on the single CHECK cycle for whichever dwell follows.
    assign timer_load_s = (state_r == ST_CHECK);

    lock_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .zero     (timer_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; unknown encodings fall back to IDLE.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE:    next_state_s = key_dig_s ? ST_ENTRY : ST_IDLE;
            ST_ENTRY: begin
                if (key_clr_s) begin
                    next_state_s = ST_IDLE;
                end else if (key_ent_s) begin
                    next_state_s = ST_CHECK;
                end else begin
                    next_state_s = ST_ENTRY;
                end
            end
            ST_CHECK: begin
                if (match_s) begin
                    next_state_s = ST_OPEN;
                end else if (fail_inc_s == MAX_FAIL_C) begin
                    next_state_s = ST_LOCKOUT;
                end else begin
                    next_state_s = ST_FAIL;
                end
            end
            ST_OPEN:    next_state_s = (timer_zero_s || key_clr_s) ? ST_IDLE : ST_OPEN;
            ST_FAIL:    next_state_s = timer_zero_s ? ST_IDLE : ST_FAIL;
            ST_LOCKOUT: next_state_s = timer_zero_s ? ST_IDLE : ST_LOCKOUT;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values, registered below.
    always_comb begin
        display_nxt_s   = display_r;
        digit_cnt_nxt_s = digit_cnt_r;
        fail_cnt_nxt_s  = fail_cnt_r;
        timer_val_s     = {TW{1'b0}};
        unlocked_nxt_s  = (next_state_s == ST_OPEN);
        alarm_nxt_s     = (next_state_s == ST_LOCKOUT);
        case (state_r)
            ST_IDLE: begin
                if (key_dig_s) begin
                    display_nxt_s   = {display_r[19:0], key_code};
                    digit_cnt_nxt_s = 3'd1;
                end else begin
                    display_nxt_s   = BLANK_DISP;
                    digit_cnt_nxt_s = 3'd0;
                end
            end
            ST_ENTRY: begin
                if (key_clr_s) begin
                    display_nxt_s   = BLANK_DISP;
                    digit_cnt_nxt_s = 3'd0;
                end else if (key_dig_s && (digit_cnt_r < 3'd6)) begin
                    display_nxt_s   = {display_r[19:0], key_code};
                    digit_cnt_nxt_s = digit_cnt_r + 3'd1;
                end else begin
                    display_nxt_s   = display_r;
                end
            end
            ST_CHECK: begin
                if (match_s) begin
                    fail_cnt_nxt_s = 3'd0;
                    timer_val_s    = TW'(OPEN_CYCLES - 1);
                end else begin
                    fail_cnt_nxt_s  = fail_inc_s;
                    display_nxt_s   = ERR_DISP;
                    digit_cnt_nxt_s = 3'd0;
                    timer_val_s     = (fail_inc_s == MAX_FAIL_C) ? TW'(LOCK_CYCLES - 1)
                                                                 : TW'(FAIL_CYCLES - 1);
                end
            end
            ST_OPEN, ST_FAIL, ST_LOCKOUT: begin
                if (next_state_s == ST_IDLE) begin
                    display_nxt_s   = BLANK_DISP;
                    digit_cnt_nxt_s = 3'd0;
                    fail_cnt_nxt_s  = (state_r == ST_LOCKOUT) ? 3'd0 : fail_cnt_r;
                end else begin
                    display_nxt_s   = display_r;
                end
            end
            default: begin
                display_nxt_s   = BLANK_DISP;
                digit_cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // Datapath and registered Moore outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            display_r   <= BLANK_DISP;
            digit_cnt_r <= 3'd0;
            fail_cnt_r  <= 3'd0;
            unlocked_r  <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            display_r   <= display_nxt_s;
            digit_cnt_r <= digit_cnt_nxt_s;
            fail_cnt_r  <= fail_cnt_nxt_s;
            unlocked_r  <= unlocked_nxt_s;
            alarm_r     <= alarm_nxt_s;
        end
    end

    assign display_code = display_r;
    assign digit_cnt    = digit_cnt_r;
    assign unlocked     = unlocked_r;
    assign alarm        = alarm_r;

endmodule
